// File: rtl/mem_stage.sv
// RV64 memory-access stage: pass-through for ALU ops, req/ready bus handshake for loads/stores.
// Optional macro MEM_MISALIGN_TRAP_EN adds mem_misalign and rejects misaligned accesses.
module mem_stage #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [3:0]      ex_mem_op,
    input  logic [AW-1:0]   ex_wd,
    input  logic            ex_wreg,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [XLEN-1:0] ex_store_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_req,
    output logic [AW-1:0]   mem_wd,
    output logic            mem_wreg,
    output logic [XLEN-1:0] mem_wdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            mem_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nx;
    logic [3:0]      op_q;
    logic [2:0]      off_q;
    logic [AW-1:0]   wd_q;
    logic            wreg_q;
    logic [XLEN-1:0] rdata_q;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    function automatic logic [1:0] size_log2(input logic [3:0] op);
        case (op)
            4'd2, 4'd6, 4'd9:  return 2'd1;
            4'd3, 4'd7, 4'd10: return 2'd2;
            4'd4, 4'd11:       return 2'd3;
            default:           return 2'd0;
        endcase
    endfunction

    logic [1:0]      ex_sz;
    logic [2:0]      ex_off, ex_off_eff, size_mask;
    logic [7:0]      base_strb;
    logic            ex_is_mem, reject, accept;
    logic [XLEN-1:0] ld_shift, ld_result;

    assign ex_sz      = size_log2(ex_mem_op);
    assign size_mask  = 3'((4'd1 << ex_sz) - 4'd1);
    assign ex_off     = ex_wdata[2:0];
    // Sub-size offset bits are dropped so the lane/strobe math always sees a natural alignment.
    assign ex_off_eff = ex_off & ~size_mask;
    assign ex_is_mem  = is_load(ex_mem_op) || is_store(ex_mem_op);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned   = |(ex_off & size_mask);
    assign reject       = misaligned;
    assign mem_misalign = (state == IDLE) && ex_valid && ex_is_mem && misaligned;
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        case (ex_sz)
            2'd0:    base_strb = 8'h01;
            2'd1:    base_strb = 8'h03;
            2'd2:    base_strb = 8'h0F;
            default: base_strb = 8'hFF;
        endcase
    end

    assign ld_shift = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (op_q)
            4'd1:    ld_result = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            4'd2:    ld_result = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            4'd3:    ld_result = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            4'd5:    ld_result = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
            4'd6:    ld_result = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
            4'd7:    ld_result = {{(XLEN-32){1'b0}},         ld_shift[31:0]};
            default: ld_result = ld_shift;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        stall_req = 1'b0;
        mem_wd    = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (ex_valid && ex_is_mem) begin
                    if (!reject) begin
                        accept    = 1'b1;
                        stall_req = 1'b1;
                        state_nx  = BUSY;
                    end
                end else begin
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg & ex_valid;
                    mem_wdata = ex_wdata;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (dmem_ready) state_nx = RESP;
            end
            RESP: begin
                // Upstream still shows this instruction here; it is not re-accepted.
                if (is_load(op_q)) begin
                    mem_wd    = wd_q;
                    mem_wreg  = wreg_q;
                    mem_wdata = ld_result;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            off_q      <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            rdata_q    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q       <= ex_mem_op;
                off_q      <= ex_off_eff;
                wd_q       <= ex_wd;
                wreg_q     <= ex_wreg;
                dmem_req   <= 1'b1;
                dmem_we    <= is_store(ex_mem_op);
                dmem_addr  <= {ex_wdata[XLEN-1:3], 3'b000};
                dmem_wdata <= ex_store_data << {ex_off_eff, 3'b000};
                dmem_wstrb <= base_strb << ex_off_eff;
            end
            if (state == BUSY && dmem_ready) begin
                rdata_q  <= dmem_rdata;
                dmem_req <= 1'b0;
            end
        end
    end

endmodule
